// File: rtl/svo_axis_timing_pkg.sv
// Shared definitions for the SVO raster-timing stage: state encoding,
// output tuser bit positions and a small window-decode helper.
package svo_axis_timing_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_RUN  = 2'd1,
        ST_SKIP = 2'd2
    } state_t;

    localparam int TU_SOF   = 0;
    localparam int TU_HSYNC = 1;
    localparam int TU_VSYNC = 2;
    localparam int TU_BLANK = 3;
    localparam int TU_W     = 4;

    // True when lo <= x < lo+len.
    function automatic logic in_window(input int x, input int lo, input int len);
        return (x >= lo) && (x < lo + len);
    endfunction

endpackage

// File: rtl/svo_axis_timing_if.sv
// AXI-Stream bundle used for both the pixel input and the raster output.
interface svo_axis_timing_if #(
    parameter int DW = 18,
    parameter int UW = 1
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;

    modport master (output tvalid, output tdata, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/svo_raster_cnt.sv
// Row-major h/v raster counters with enable, wrap flag and position decode.
module svo_raster_cnt
    import svo_axis_timing_pkg::*;
#(
    parameter int HOR_PIXELS      = 640,
    parameter int HOR_FRONT_PORCH = 16,
    parameter int HOR_SYNC        = 96,
    parameter int HOR_BACK_PORCH  = 48,
    parameter int VER_PIXELS      = 480,
    parameter int VER_FRONT_PORCH = 10,
    parameter int VER_SYNC        = 2,
    parameter int VER_BACK_PORCH  = 33
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic active_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic fstart_o,
    output logic wrap_o
);
    localparam int H_TOTAL = HOR_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
    localparam int V_TOTAL = VER_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
    localparam int HW = ($clog2(H_TOTAL) > 0) ? $clog2(H_TOTAL) : 1;
    localparam int VW = ($clog2(V_TOTAL) > 0) ? $clog2(V_TOTAL) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_last, v_last;

    assign h_last   = (h_q == H_LAST);
    assign v_last   = (v_q == V_LAST);
    assign wrap_o   = h_last && v_last;
    assign fstart_o = (h_q == '0) && (v_q == '0);
    assign active_o = (int'(h_q) < HOR_PIXELS) && (int'(v_q) < VER_PIXELS);
    assign hsync_o  = in_window(int'(h_q), HOR_PIXELS + HOR_FRONT_PORCH, HOR_SYNC);
    assign vsync_o  = in_window(int'(v_q), VER_PIXELS + VER_FRONT_PORCH, VER_SYNC);

    // Next position: advance h, carry into v at end of line, wrap at end of frame.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (en_i) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end
endmodule

// File: rtl/svo_axis_timing.sv
// Turns a framed pixel stream into a full raster (active + blanking) with
// sync flags, locking onto the SOF flag and realigning on bad frame lengths.
module svo_axis_timing
    import svo_axis_timing_pkg::*;
#(
    parameter int HOR_PIXELS      = 640,
    parameter int HOR_FRONT_PORCH = 16,
    parameter int HOR_SYNC        = 96,
    parameter int HOR_BACK_PORCH  = 48,
    parameter int VER_PIXELS      = 480,
    parameter int VER_FRONT_PORCH = 10,
    parameter int VER_SYNC        = 2,
    parameter int VER_BACK_PORCH  = 33,
    parameter int BITS_PER_PIXEL  = 18
) (
    input  logic               clk,
    input  logic               reset,
    svo_axis_timing_if.slave   in_axis,
    svo_axis_timing_if.master  out_axis,
    output logic               locked,
    output logic               err_sof_early,
    output logic               err_sof_missing
);
    state_t                    state_q, state_d;
    logic                      from_run_q, from_run_d;
    logic                      out_valid_q, out_valid_d;
    logic [BITS_PER_PIXEL-1:0] out_data_q, out_data_d;
    logic [TU_W-1:0]           out_user_q, out_user_d;
    logic                      early_q, early_d;
    logic                      missing_q, missing_d;

    logic active, hsync, vsync, fstart, wrap;
    logic slot_free, mid_sof, in_ready, emit, emit_pix;
    logic [TU_W-1:0] beat_user;

    svo_raster_cnt #(
        .HOR_PIXELS      (HOR_PIXELS),
        .HOR_FRONT_PORCH (HOR_FRONT_PORCH),
        .HOR_SYNC        (HOR_SYNC),
        .HOR_BACK_PORCH  (HOR_BACK_PORCH),
        .VER_PIXELS      (VER_PIXELS),
        .VER_FRONT_PORCH (VER_FRONT_PORCH),
        .VER_SYNC        (VER_SYNC),
        .VER_BACK_PORCH  (VER_BACK_PORCH)
    ) u_raster (
        .clk      (clk),
        .reset    (reset),
        .en_i     (emit),
        .active_o (active),
        .hsync_o  (hsync),
        .vsync_o  (vsync),
        .fstart_o (fstart),
        .wrap_o   (wrap)
    );

    // Next-state, input acceptance and output beat selection.
    always_comb begin
        slot_free   = !out_valid_q || out_axis.tready;
        mid_sof     = in_axis.tvalid && in_axis.tuser[0] && !fstart;
        in_ready    = slot_free && ((state_q == ST_SYNC) ||
                                    ((state_q == ST_RUN) && active && !mid_sof));
        state_d     = state_q;
        from_run_d  = from_run_q;
        out_valid_d = out_valid_q && !out_axis.tready;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        early_d     = 1'b0;
        missing_d   = 1'b0;
        emit        = 1'b0;
        emit_pix    = 1'b0;
        beat_user   = '0;
        beat_user[TU_SOF]   = fstart;
        beat_user[TU_HSYNC] = hsync;
        beat_user[TU_VSYNC] = vsync;
        beat_user[TU_BLANK] = !active;

        if (slot_free) begin
            case (state_q)
                ST_SYNC: begin
                    if (in_axis.tvalid) begin
                        if (in_axis.tuser[0]) begin
                            emit       = 1'b1;
                            emit_pix   = 1'b1;
                            state_d    = ST_RUN;
                            from_run_d = 1'b0;
                        end else begin
                            // Leftover beats of an over-long frame are flushed here.
                            missing_d = from_run_q;
                        end
                    end
                end
                ST_RUN: begin
                    if (!active) begin
                        emit = 1'b1;
                    end else if (mid_sof) begin
                        // Short frame: pad the rest with black and keep the SOF for SYNC.
                        emit    = 1'b1;
                        early_d = 1'b1;
                        state_d = ST_SKIP;
                    end else if (in_axis.tvalid) begin
                        emit     = 1'b1;
                        emit_pix = 1'b1;
                    end
                end
                ST_SKIP: emit = 1'b1;
                default: state_d = ST_SYNC;
            endcase
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_pix ? in_axis.tdata : '0;
            out_user_d  = beat_user;
            if (wrap) begin
                state_d    = ST_SYNC;
                from_run_d = (state_q == ST_RUN);
            end
        end
    end

    // State and registered output beat; reset drops any beat in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            from_run_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= '0;
            early_q     <= 1'b0;
            missing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            from_run_q  <= from_run_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            early_q     <= early_d;
            missing_q   <= missing_d;
        end
    end

    assign in_axis.tready   = in_ready;
    assign out_axis.tvalid  = out_valid_q;
    assign out_axis.tdata   = out_data_q;
    assign out_axis.tuser   = out_user_q;
    assign locked           = (state_q != ST_SYNC);
    assign err_sof_early    = early_q;
    assign err_sof_missing  = missing_q;
endmodule

// File: tb/tb_svo_axis_timing.sv
// Directed bench for svo_axis_timing on an 8x6 raster (4x3 active).
module tb_svo_axis_timing;
    localparam int HP = 4, HF = 1, HS = 2, HB = 1;
    localparam int VP = 3, VF = 1, VS = 1, VB = 1;
    localparam int BPP = 18;
    localparam int HT = HP + HF + HS + HB;
    localparam int VT = VP + VF + VS + VB;

    typedef logic [BPP+3:0] beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic locked, err_sof_early, err_sof_missing;

    svo_axis_timing_if #(.DW(BPP), .UW(1)) in_axis ();
    svo_axis_timing_if #(.DW(BPP), .UW(4)) out_axis ();

    svo_axis_timing #(
        .HOR_PIXELS(HP), .HOR_FRONT_PORCH(HF), .HOR_SYNC(HS), .HOR_BACK_PORCH(HB),
        .VER_PIXELS(VP), .VER_FRONT_PORCH(VF), .VER_SYNC(VS), .VER_BACK_PORCH(VB),
        .BITS_PER_PIXEL(BPP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_axis         (in_axis),
        .out_axis        (out_axis),
        .locked          (locked),
        .err_sof_early   (err_sof_early),
        .err_sof_missing (err_sof_missing)
    );

    always #5 clk = ~clk;

    logic [BPP:0] in_q[$];
    beat_t        out_log[$];
    beat_t        ref_q[$];
    logic         lock_hist[$];
    int           early_cyc[$];
    int           n_missing;
    int           first_out;
    int           checks = 0;
    int           errors = 0;
    int           used;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t ref_beat(input int h, input int v, input logic [BPP-1:0] px,
                                       input bit skip);
        logic act, hs, vs, fs;
        act = (h < HP) && (v < VP);
        hs  = (h >= HP + HF) && (h < HP + HF + HS);
        vs  = (v >= VP + VF) && (v < VP + VF + VS);
        fs  = (h == 0) && (v == 0);
        return {!act, vs, hs, fs, (act && !skip) ? px : {BPP{1'b0}}};
    endfunction

    task automatic push_input_frame(input logic [BPP-1:0] base, input int n);
        for (int k = 0; k < n; k++)
            in_q.push_back({(k == 0), base + BPP'(k)});
    endtask

    // Expected raster for one frame whose first n active pixels carry data.
    task automatic push_ref_frame(input logic [BPP-1:0] base, input int n);
        int k = 0;
        for (int idx = 0; idx < HT * VT; idx++) begin
            int h = idx % HT;
            int v = idx / HT;
            if (h < HP && v < VP) begin
                ref_q.push_back(ref_beat(h, v, base + BPP'(k), k >= n));
                k++;
            end else begin
                ref_q.push_back(ref_beat(h, v, '0, 1'b1));
            end
        end
    endtask

    task automatic clear_logs();
        out_log.delete();
        ref_q.delete();
        lock_hist.delete();
        early_cyc.delete();
        n_missing = 0;
        first_out = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_axis.tvalid = 1'b0;
        in_axis.tuser  = '0;
        in_axis.tdata  = '0;
        out_axis.tready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One iteration per clock: drive at negedge, sample 1 ns later, pop on handshake.
    task automatic run(input int maxc, input int target, input bit rnd, output int cyc);
        bit    stall_prev = 1'b0;
        beat_t prev = '0;
        beat_t cur;
        logic [BPP:0] hd;
        bit    in_fire;
        cyc = 0;
        for (int c = 0; c < maxc; c++) begin
            if (target > 0 && out_log.size() >= target) break;
            cyc = c + 1;
            if (in_q.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
                hd = in_q[0];
                in_axis.tvalid = 1'b1;
                in_axis.tuser  = hd[BPP];
                in_axis.tdata  = hd[BPP-1:0];
            end else begin
                in_axis.tvalid = 1'b0;
                in_axis.tuser  = '0;
                in_axis.tdata  = '0;
            end
            out_axis.tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            cur = {out_axis.tuser, out_axis.tdata};
            if (stall_prev)
                check("stall_stable", {out_axis.tvalid, cur}, {1'b1, prev});
            if (out_axis.tvalid && out_axis.tready) begin
                out_log.push_back(cur);
                if (first_out < 0) first_out = c;
            end
            stall_prev = out_axis.tvalid && !out_axis.tready;
            prev = cur;
            lock_hist.push_back(locked);
            if (err_sof_early) early_cyc.push_back(c);
            if (err_sof_missing) n_missing++;
            in_fire = in_axis.tvalid && in_axis.tready;
            @(negedge clk);
            if (in_fire) void'(in_q.pop_front());
        end
        in_axis.tvalid = 1'b0;
        out_axis.tready = 1'b1;
    endtask

    task automatic compare_logs(input string tag);
        int n;
        check({tag, "_count"}, out_log.size(), ref_q.size());
        n = (out_log.size() < ref_q.size()) ? out_log.size() : ref_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", tag, i), 32'(out_log[i]), 32'(ref_q[i]));
    endtask

    initial begin
        in_axis.tvalid = 1'b0;
        in_axis.tuser  = '0;
        in_axis.tdata  = '0;
        out_axis.tready = 1'b1;

        // Reset state.
        clear_logs();
        do_reset();
        check("rst_tvalid", out_axis.tvalid, 1'b0);
        check("rst_tdata", out_axis.tdata, '0);
        check("rst_tuser", out_axis.tuser, '0);
        check("rst_locked", locked, 1'b0);
        check("rst_err_early", err_sof_early, 1'b0);
        check("rst_err_missing", err_sof_missing, 1'b0);
        check("rst_in_tready", in_axis.tready, 1'b1);

        // Two clean frames, back-to-back.
        push_input_frame(18'h01000, 12);
        push_input_frame(18'h02000, 12);
        push_ref_frame(18'h01000, 12);
        push_ref_frame(18'h02000, 12);
        run(97, 0, 1'b0, used);
        compare_logs("s1");
        check("s1_lock_c0", lock_hist[0], 1'b0);
        check("s1_lock_c1", lock_hist[1], 1'b1);
        check("s1_lock_c47", lock_hist[47], 1'b1);
        check("s1_lock_c48", lock_hist[48], 1'b0);
        check("s1_lock_c49", lock_hist[49], 1'b1);
        check("s1_first_out", first_out, 1);
        check("s1_missing", n_missing, 0);
        check("s1_early", early_cyc.size(), 0);
        check("s1_in_left", in_q.size(), 0);

        // Three stray beats before the first SOF after reset.
        clear_logs();
        do_reset();
        for (int i = 0; i < 3; i++) in_q.push_back({1'b0, 18'h3AAA0 + BPP'(i)});
        push_input_frame(18'h03000, 12);
        push_ref_frame(18'h03000, 12);
        run(52, 0, 1'b0, used);
        compare_logs("s2");
        check("s2_first_out", first_out, 4);
        check("s2_missing", n_missing, 0);
        check("s2_in_left", in_q.size(), 0);

        // Short frame (7 pixels) followed by a clean frame.
        clear_logs();
        push_input_frame(18'h04000, 7);
        push_input_frame(18'h05000, 12);
        push_ref_frame(18'h04000, 7);
        push_ref_frame(18'h05000, 12);
        run(97, 0, 1'b0, used);
        compare_logs("s3");
        check("s3_early_n", early_cyc.size(), 1);
        check("s3_early_cyc", early_cyc[0], 12);
        check("s3_missing", n_missing, 0);
        check("s3_in_left", in_q.size(), 0);

        // Long frame (14 pixels) followed by a clean frame.
        clear_logs();
        push_input_frame(18'h06000, 14);
        push_input_frame(18'h07000, 12);
        push_ref_frame(18'h06000, 12);
        push_ref_frame(18'h07000, 12);
        run(99, 0, 1'b0, used);
        compare_logs("s4");
        check("s4_missing", n_missing, 2);
        check("s4_early", early_cyc.size(), 0);
        check("s4_lock_c49", lock_hist[49], 1'b0);
        check("s4_lock_c51", lock_hist[51], 1'b1);
        check("s4_in_left", in_q.size(), 0);

        // Random backpressure and input gaps.
        clear_logs();
        do_reset();
        push_input_frame(18'h01000, 12);
        push_input_frame(18'h02000, 12);
        push_ref_frame(18'h01000, 12);
        push_ref_frame(18'h02000, 12);
        run(3000, 96, 1'b1, used);
        compare_logs("s5");
        check("s5_missing", n_missing, 0);
        check("s5_early", early_cyc.size(), 0);
        check("s5_in_left", in_q.size(), 0);

        // Reset in the middle of a frame.
        clear_logs();
        do_reset();
        push_input_frame(18'h08000, 12);
        push_ref_frame(18'h08000, 12);
        run(20, 0, 1'b0, used);
        while (ref_q.size() > 19) void'(ref_q.pop_back());
        compare_logs("s6_pre");
        out_axis.tready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("s6_rst_tvalid", out_axis.tvalid, 1'b0);
        check("s6_rst_locked", locked, 1'b0);
        reset = 1'b0;
        out_axis.tready = 1'b1;
        clear_logs();
        in_q.delete();
        push_input_frame(18'h09000, 12);
        push_ref_frame(18'h09000, 12);
        run(49, 0, 1'b0, used);
        compare_logs("s6_post");
        check("s6_first_out", first_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/svo_axis_timing.md
# svo_axis_timing

Converts a framed pixel AXI-Stream into a raster-timed video stream with blanking, hsync and vsync. The pixel stream has one beat per active pixel and tuser[0] marking start of frame; the test-card generator produces this kind of stream. Each output beat is one pixel clock of the full raster, so a downstream serializer (DVI/TMDS) can consume one beat per pixel. The block keeps frame lock on the SOF flag and recovers automatically from short or long input frames.

## Interface
- HOR_PIXELS, 640: active pixels per line
- HOR_FRONT_PORCH, 16 / HOR_SYNC, 96 / HOR_BACK_PORCH, 48: horizontal blanking, in beats
- VER_PIXELS, 480: active lines
- VER_FRONT_PORCH, 10 / VER_SYNC, 2 / VER_BACK_PORCH, 33: vertical blanking, in lines
- BITS_PER_PIXEL, 18: pixel width
- Derived: H_TOTAL is the sum of the four horizontal parameters. V_TOTAL is the sum of the four vertical parameters.
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- in_axis_tvalid  in  1  input beat valid
- in_axis_tready  out  1  input beat accepted
- in_axis_tdata  in  BITS_PER_PIXEL  pixel
- in_axis_tuser  in  1  [0] start of frame
- out_axis_tvalid  out  1  output beat valid
- out_axis_tready  in  1  downstream ready
- out_axis_tdata  out  BITS_PER_PIXEL  pixel; 0 during blanking
- out_axis_tuser  out  4  [0] frame start (h=0,v=0), [1] hsync, [2] vsync, [3] blank
- locked  out  1  high in states RUN/SKIP
- err_sof_early  out  1  one-cycle pulse when SOF arrives mid-frame
- err_sof_missing  out  1  one-cycle pulse per non-SOF beat dropped while realigning after lock

## Operation
- Raster counters: h runs 0..H_TOTAL-1 and v runs 0..V_TOTAL-1, row-major, both wrap to 0.
  - Active when h<HOR_PIXELS and v<VER_PIXELS.
  - hsync when HOR_PIXELS+HOR_FRONT_PORCH ≤ h < HOR_PIXELS+HOR_FRONT_PORCH+HOR_SYNC. vsync is the same form on v, applied to the whole line.
  - blank = !active.
- "Slot free" = !out_axis_tvalid || out_axis_tready. Nothing advances unless the slot is free.
- States: SYNC (reset state), RUN, SKIP.
- SYNC (counters held at 0,0):
  - in_axis_tready=1.
  - A non-SOF input beat is dropped. err_sof_missing pulses if the previous state was RUN.
  - An SOF beat is emitted as pixel (0,0), the counters advance, and the state goes to RUN.
- RUN, active position, input valid, no SOF: consume the beat and emit the pixel.
- RUN, active position, SOF seen at (h,v)≠(0,0):
  - Do not consume the beat; emit 0 with blank=0.
  - Pulse err_sof_early and go to SKIP.
- RUN, active position, input not valid: emit nothing (output stalls); counters hold.
- RUN, blanking position: in_axis_tready=0; emit a blank beat.
- SKIP: active positions emit 0 without consuming; blanking is emitted as in RUN.
- Any state: when the counters wrap to (0,0) the state goes to SYNC, so the SOF beat at the head of the input is picked up there.
- in_axis_tready is combinational: slot free AND (state SYNC, OR state RUN at an active position and the head beat is not a mid-frame SOF).
- Reset mid-frame: next cycle the state is SYNC, counters are 0, and any output beat in flight is discarded.

## Timing
- Reset values:
  - out_axis_tvalid=0, out_axis_tdata=0, out_axis_tuser=0
  - locked=0, both error pulses 0
  - h=v=0, state SYNC
- Latency is one cycle: a beat accepted, or a blank beat generated, at edge N is on the output after edge N. The output is registered.
- Full throughput of one beat per cycle while out_axis_tready=1 and input is available for active positions.
- out_axis_tvalid, tdata and tuser stay stable while tvalid=1 and tready=0.
- locked rises one cycle after SOF acceptance in SYNC and falls one cycle after a wrap into SYNC.

## Structure
- Package svo_axis_timing_pkg holds:
  - state encoding (SYNC/RUN/SKIP)
  - tuser bit indices (TU_SOF=0, TU_HSYNC=1, TU_VSYNC=2, TU_BLANK=3)
- Sub-module svo_raster_cnt contains the h/v counters with enable, wrap, and active/hsync/vsync/frame-start decode. It has the same timing parameters and is reusable by other SVO stages.

## Test plan
All scenarios use the small raster HOR 4/1/2/1 (H_TOTAL=8) and VER 3/1/1/1 (V_TOTAL=6): 48 beats per frame, 12 active.

- Reset, then 2 clean frames of 12 pixels with tready=1 -> 96 output beats back-to-back, tuser[0] only on beats 0 and 48, hsync at h=5,6, vsync on line 4, pixels in order, locked=1 from cycle 2.
- Three non-SOF beats, then a clean frame -> 3 beats dropped, no err_sof_missing (never locked), first output one cycle after SOF.
- Input frame of 7 pixels then SOF -> err_sof_early once at (h=3,v=1); the remaining 5 active positions output 0; the next frame is aligned.
- Input frame of 14 pixels -> after wrap, 2 drops with 2 err_sof_missing pulses, then relock on the next SOF.
- Random tready (50%) and random input gaps -> output sequence identical to the scenario 1 reference, data stable while stalled.
- Reset asserted at frame beat 20 -> out_axis_tvalid=0 next cycle, state SYNC; the next SOF restarts at (0,0).
